// File: rtl/alu_adder_flags.sv
// alu_adder_flags
//   Two-stage add-with-carry unit with a persistent {Z,N,C,V} flag register
//   and a small result queue.
//
//   Stage p0 (accept): LHSIn, CarrySelect and FlagWrite are captured when
//   in_valid && in_ready. The matching RHSIn arrives one cycle later from
//   an external register, so it is consumed directly in stage p1.
//   Stage p1 (execute): {c,R} = LHS + RHSIn + cin. The flag register is
//   optionally updated. {R, post-op flags} is pushed into the queue.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset_n      synchronous active-low reset
//   in_valid     op offered
//   in_ready     op accepted when in_valid && in_ready
//   LHSIn        left operand (accept cycle)
//   RHSIn        right operand (cycle after accept)
//   CarrySelect  00=0, 01=1, 10=C, 11=~C
//   FlagWrite    op updates the flag register
//   ResultOut    result at queue head (0 when empty)
//   FlagsOut     {Z,N,C,V} for the head entry (0 when empty)
//   out_valid    queue non-empty
//   out_ready    head popped when out_valid && out_ready
module alu_adder_flags #(
  parameter int WIDTH  = 8,
  parameter int QDEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] LHSIn,
  input  logic [WIDTH-1:0] RHSIn,
  input  logic [1:0]       CarrySelect,
  input  logic             FlagWrite,
  output logic [WIDTH-1:0] ResultOut,
  output logic [3:0]       FlagsOut,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);

  function automatic logic carry_in(input logic [1:0] sel, input logic c);
    logic r;
    case (sel)
      2'b00:   r = 1'b0;
      2'b01:   r = 1'b1;
      2'b10:   r = c;
      default: r = ~c;
    endcase
    return r;
  endfunction

  // {Z,N,C,V}; V is signed overflow: operands agree in sign, result differs.
  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH:0]   s);
    logic z, n, c, v;
    z = (s[WIDTH-1:0] == '0);
    n = s[WIDTH-1];
    c = s[WIDTH];
    v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    return {z, n, c, v};
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic             acc_p0;
  logic             vld_p1;
  logic [WIDTH-1:0] lhs_p1;
  logic [1:0]       csel_p1;
  logic             fwr_p1;
  logic             cin_p1;
  logic [WIDTH:0]   sum_p1;
  logic [3:0]       flags_new_p1;
  logic [3:0]       flags_post_p1;
  logic [3:0]       flag_r;

  logic [WIDTH-1:0] mem_res [QDEPTH];
  logic [3:0]       mem_flg [QDEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW:0]      occ;
  logic             push;
  logic             pop;

  // ---- stage p0: accept ----
  // Occupancy counts the op in p1 as already queued; a same-cycle pop is
  // deliberately ignored so a push can never find the queue full.
  assign occ      = {1'b0, count} + {{CW{1'b0}}, vld_p1};
  assign in_ready = (occ <= (CW+1)'(QDEPTH - 1));
  assign acc_p0   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= acc_p0;
  end

  always_ff @(posedge clk) begin
    if (acc_p0) begin
      lhs_p1  <= LHSIn;
      csel_p1 <= CarrySelect;
      fwr_p1  <= FlagWrite;
    end
  end

  // ---- stage p1: execute, flag update, queue push ----
  assign cin_p1        = carry_in(csel_p1, flag_r[1]);
  assign sum_p1        = {1'b0, lhs_p1} + {1'b0, RHSIn} + {{WIDTH{1'b0}}, cin_p1};
  assign flags_new_p1  = calc_flags(lhs_p1, RHSIn, sum_p1);
  assign flags_post_p1 = fwr_p1 ? flags_new_p1 : flag_r;

  always_ff @(posedge clk) begin
    if (!reset_n)              flag_r <= '0;
    else if (vld_p1 && fwr_p1) flag_r <= flags_new_p1;
  end

  assign push = vld_p1;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_res[wr_ptr] <= sum_p1[WIDTH-1:0];
      mem_flg[wr_ptr] <= flags_post_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- queue head ----
  assign out_valid = (count != '0);
  assign ResultOut = out_valid ? mem_res[rd_ptr] : '0;
  assign FlagsOut  = out_valid ? mem_flg[rd_ptr] : '0;

endmodule

// File: doc/alu_adder_flags.md
ALU_ADDER_FLAGS -- requirements
Module: alu_adder_flags

Interface
REQ-001 Parameter WIDTH, default 8, datapath width; only 8 is supported.
REQ-002 Parameter QDEPTH, default 3, result queue depth; only 3 is supported.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 in_valid  in  1  an op is offered this cycle.
REQ-006 in_ready  out  1  the op is accepted when in_valid and in_ready are both high.
REQ-007 LHSIn  in  8  left operand; presented in the accept cycle, the same cycle LogicSelect/RHS are presented to logic_rhs.
REQ-008 RHSIn  in  8  logic_rhs registered RHSOut; valid exactly one cycle after accept.
REQ-009 CarrySelect  in  2  carry-in: 00=0, 01=1, 10=flag C, 11=~flag C; sampled at accept.
REQ-010 FlagWrite  in  1  when high, the op updates the flag register; sampled at accept.
REQ-011 ResultOut  out  8  result at queue head.
REQ-012 FlagsOut  out  4  {Z,N,C,V} snapshot for the head entry.
REQ-013 out_valid  out  1  queue non-empty.
REQ-014 out_ready  in  1  the head is popped when out_valid and out_ready are both high.

Function
REQ-015 Stage 1 shall register LHSIn, CarrySelect and FlagWrite on accept and set s1_valid for exactly the next cycle, aligning them with RHSIn.
REQ-016 When s1_valid is set, the block shall compute {c,R} = LHS + RHSIn + cin as a 9-bit sum; cin shall use the flag register value at the start of that cycle.
REQ-017 Flags shall be: Z = (R==0); N = R[7]; C = c; V = (LHS[7]==RHSIn[7]) & (R[7]!=LHS[7]); subtraction via inverted RHS with cin=1 gives C=1 for no borrow.
REQ-018 If FlagWrite=1, the flag register shall load {Z,N,C,V} at the end of the s1 cycle; otherwise it shall hold.
REQ-019 Each s1 cycle shall push {R, post-op flag register value} into the queue unconditionally; RHSIn is never re-read.
REQ-020 in_ready shall equal (queue_count + s1_valid) <= 2, computed without regard to a same-cycle pop, so a push can never overflow.
REQ-021 Latency: an op accepted in cycle k with an empty queue shall appear at the head (out_valid=1) in cycle k+2; sustained throughput with out_ready=1 shall be one op per cycle.
REQ-022 A simultaneous push and pop shall leave the count unchanged and preserve FIFO order; a pop when empty shall have no effect.
REQ-023 Back-to-back ops shall see flag updates in program order: an op in s1 in cycle k+1 uses flags written by the op in s1 in cycle k.
REQ-024 When the queue is empty, ResultOut and FlagsOut shall be driven to 0.
REQ-025 in_valid while in_ready=0 shall be ignored; the upstream holds the op, and the LogicSelect sequencing toward logic_rhs is the upstream's responsibility.

Reset
REQ-026 While reset_n=0 at a rising edge: queue_count=0, s1_valid=0, flag register=0, out_valid=0, ResultOut=0, FlagsOut=0, in_ready=1 in the cycle after release.
REQ-027 Reset mid-operation shall discard the s1 and queue contents; RHSIn arriving the cycle after release shall be ignored, and no op shall be accepted during reset.

Verification
REQ-028 reset_n low 2 cycles with in_valid=1 and out_ready=1 -> no push, out_valid=0, FlagsOut=0, in_ready=1 after release.
REQ-029 LHS=0x7F, RHS=0x01, CarrySelect=00, FlagWrite=1 -> ResultOut=0x80, FlagsOut Z0 N1 C0 V1, out_valid in cycle k+2.
REQ-030 LHS=0x05, RHS=0xFA, CarrySelect=01 -> ResultOut=0x00, Z=1, C=1, N=0, V=0.
REQ-031 Back-to-back: 0xFF+0x01, cin 00, FlagWrite=1, then 0x00+0x00, CarrySelect=10 -> results 0x00 (C=1) then 0x01 (C=0), in consecutive cycles.
REQ-032 out_ready=0 with 5 ops offered -> exactly 3 accepted and in_ready=0; then out_ready=1 -> 3 results drained in order, the remaining 2 accepted, none lost or duplicated.
REQ-033 FlagWrite=0 op after flags=C1 -> flag register unchanged and entry FlagsOut equals the prior flags.
